// File: rtl/shift_pkg.sv
// shift_pkg: shifter op codes and the mux-level split across pipeline stages
package shift_pkg;
   localparam logic [2:0] SHIFT_SLL = 3'd0;
   localparam logic [2:0] SHIFT_SRL = 3'd1;
   localparam logic [2:0] SHIFT_SRA = 3'd2;
   localparam logic [2:0] SHIFT_ROL = 3'd3;
   localparam logic [2:0] SHIFT_ROR = 3'd4;
   // First mux level owned by stage k; earlier stages absorb the remainder levels.
   function automatic int lvl_lo(input int levels, input int stages, input int k);
      return k * (levels / stages) + ((k < levels % stages) ? k : levels % stages);
   endfunction
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one elastic register stage applying right-rotate/shift mux levels LVL_LO..LVL_HI
module shift_stage import shift_pkg::*; #(
   parameter int WIDTH  = 32,
   parameter int LVL_LO = 0,
   parameter int LVL_HI = 0,
   localparam int LV    = $clog2(WIDTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [WIDTH-1:0] data_i,
   input  logic            ext_i,
   input  logic [LV-1:0]   amt_i,
   input  logic            fill_i,
   input  logic            rot_i,
   input  logic            rev_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic            ext_o,
   output logic [LV-1:0]   amt_o,
   output logic            fill_o,
   output logic            rot_o,
   output logic            rev_o
);
   localparam logic [WIDTH-1:0] ONES = '1;
   logic             valid_q, ext_q, ext_d, fill_q, rot_q, rev_q;
   logic [WIDTH-1:0] data_q, data_d, last_d;
   logic [LV-1:0]    amt_q;
   // ext tracks the last bit to leave the low end, which is the carry for every op
   always_comb begin
      data_d = data_i;
      ext_d  = ext_i;
      last_d = data_i;
      for (int j = LVL_LO; j <= LVL_HI; j++) begin
         if (amt_i[j]) begin
            last_d = data_d >> ((1 << j) - 1);
            ext_d  = last_d[0];
            data_d = (data_d >> (1 << j)) |
                     (rot_i ? data_d << (WIDTH - (1 << j)) : fill_i ? ~(ONES >> (1 << j)) : '0);
         end
      end
   end
   assign ready_o = !valid_q || ready_i;
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ext_q   <= 1'b0;
         amt_q   <= '0;
         fill_q  <= 1'b0;
         rot_q   <= 1'b0;
         rev_q   <= 1'b0;
      end else if (ready_o) begin
         valid_q <= valid_i;
         data_q  <= data_d;
         ext_q   <= ext_d;
         amt_q   <= amt_i;
         fill_q  <= fill_i;
         rot_q   <= rot_i;
         rev_q   <= rev_i;
      end
   end
   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign ext_o   = ext_q;
   assign amt_o   = amt_q;
   assign fill_o  = fill_q;
   assign rot_o   = rot_q;
   assign rev_o   = rev_q;
endmodule

// File: rtl/shift_unit_pipelined.sv
// shift_unit_pipelined: elastic multi-mode shifter (SLL/SRL/SRA/ROL/ROR) with zero and carry flags
module shift_unit_pipelined import shift_pkg::*; #(
   parameter int WIDTH  = 32,
   parameter int AMT_W  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zero,
   output logic             out_carry
);
   localparam int LV = $clog2(WIDTH);
   logic [STAGES:0]            vld, rdy, ext, fill, rot, rev;
   logic [STAGES:0][WIDTH-1:0] dat;
   logic [STAGES:0][LV-1:0]    amt;
   logic [WIDTH-1:0]           rin, core, dat0, dl_rev;
   logic [LV-1:0]              amt0;
   logic                       is_sh, sat, ext0, fill0, rot0, rev0, unused_ctrl;
   // Left ops run through the right-only core on bit-reversed data; saturation is folded in here
   always_comb begin
      rin   = {<<{in_data}};
      rev0  = in_op == SHIFT_SLL || in_op == SHIFT_ROL;
      rot0  = in_op == SHIFT_ROL || in_op == SHIFT_ROR;
      is_sh = in_op == SHIFT_SLL || in_op == SHIFT_SRL || in_op == SHIFT_SRA;
      core  = rev0 ? rin : in_data;
      fill0 = in_op == SHIFT_SRA && in_data[WIDTH-1];
      sat   = is_sh && (in_amt >> LV) != '0;
      amt0  = (is_sh || rot0) && !sat ? in_amt[LV-1:0] : '0;
      dat0  = sat ? {WIDTH{fill0}} : core;
      ext0  = sat && (in_amt == AMT_W'(WIDTH) ? core[WIDTH-1] : fill0);
   end
   assign vld[0]      = in_valid;
   assign dat[0]      = dat0;
   assign ext[0]      = ext0;
   assign amt[0]      = amt0;
   assign fill[0]     = fill0;
   assign rot[0]      = rot0;
   assign rev[0]      = rev0;
   assign rdy[STAGES] = out_ready;
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      shift_stage #(
         .WIDTH (WIDTH),
         .LVL_LO(lvl_lo(LV, STAGES, k)),
         .LVL_HI(lvl_lo(LV, STAGES, k + 1) - 1)
      ) u_stage (
         .clk    (clk),
         .rst    (rst),
         .valid_i(vld[k]),
         .ready_o(rdy[k]),
         .data_i (dat[k]),
         .ext_i  (ext[k]),
         .amt_i  (amt[k]),
         .fill_i (fill[k]),
         .rot_i  (rot[k]),
         .rev_i  (rev[k]),
         .valid_o(vld[k+1]),
         .ready_i(rdy[k+1]),
         .data_o (dat[k+1]),
         .ext_o  (ext[k+1]),
         .amt_o  (amt[k+1]),
         .fill_o (fill[k+1]),
         .rot_o  (rot[k+1]),
         .rev_o  (rev[k+1])
      );
   end
   always_comb dl_rev = {<<{dat[STAGES]}};
   assign unused_ctrl = ^{amt[STAGES], fill[STAGES], rot[STAGES]};
   assign in_ready    = !rst && rdy[0];
   assign out_valid   = !rst && vld[STAGES];
   assign out_data    = rst ? '0 : rev[STAGES] ? dl_rev : dat[STAGES];
   assign out_zero    = out_valid && out_data == '0;
   assign out_carry   = !rst && ext[STAGES];
endmodule

// File: tb/tb_shift_unit_pipelined.sv
// tb_shift_unit_pipelined: directed and randomized checks of the shifter against a behavioural model
module tb_shift_unit_pipelined;
   localparam int W = 32;
   localparam int S = 2;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic [W-1:0] in_data = '0;
   logic [31:0] in_amt = '0;
   logic [2:0] in_op = '0;
   logic in_ready, out_valid, out_zero, out_carry;
   logic [W-1:0] out_data;
   int tests = 0, fails = 0;
   typedef struct {logic [W-1:0] d; logic c; logic z;} exp_t;
   exp_t exp_q[$];

   shift_unit_pipelined #(.WIDTH(W), .AMT_W(32), .STAGES(S)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_amt(in_amt), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_zero(out_zero), .out_carry(out_carry));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
      tests++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h", nm, got, req);
      end
   endtask

   // Returns {carry, result} straight from the shift/rotate definitions
   function automatic logic [W:0] model(input logic [W-1:0] d, input logic [31:0] n, input logic [2:0] op);
      logic [W-1:0] r;
      logic c;
      int m;
      r = d;
      c = 1'b0;
      case (op)
         3'd0: if (n >= W) begin r = '0; c = (n == W) ? d[0] : 1'b0; end
               else if (n != 0) begin r = d << n; c = d[W-n]; end
         3'd1: if (n >= W) begin r = '0; c = (n == W) ? d[W-1] : 1'b0; end
               else if (n != 0) begin r = d >> n; c = d[n-1]; end
         3'd2: if (n >= W) begin r = {W{d[W-1]}}; c = d[W-1]; end
               else if (n != 0) begin r = $signed(d) >>> n; c = d[n-1]; end
         3'd3: begin m = int'(n % W); if (m != 0) begin r = (d << m) | (d >> (W - m)); c = r[0]; end end
         3'd4: begin m = int'(n % W); if (m != 0) begin r = (d >> m) | (d << (W - m)); c = r[W-1]; end end
         default: ;
      endcase
      return {c, r};
   endfunction

   // Scoreboard/compare process, sampling mid-cycle when inputs and outputs are settled
   logic hold = 1'b0, hc, hz;
   logic [W-1:0] hd;
   initial forever begin
      exp_t e;
      logic [W:0] m;
      @(negedge clk);
      if (rst) begin
         chk("reset out_valid", out_valid, 0);
         exp_q.delete();
         hold = 1'b0;
      end else begin
         if (hold) begin
            chk("hold valid", out_valid, 1);
            chk("hold data", out_data, hd);
            chk("hold carry", out_carry, hc);
            chk("hold zero", out_zero, hz);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected output: got %h, required no result", out_data);
            end else begin
               e = exp_q.pop_front();
               chk("model data", out_data, e.d);
               chk("model carry", out_carry, e.c);
               chk("model zero", out_zero, e.z);
            end
         end
         hold = out_valid && !out_ready;
         hd = out_data;
         hc = out_carry;
         hz = out_zero;
         if (in_valid && in_ready) begin
            m = model(in_data, in_amt, in_op);
            exp_q.push_back('{d: m[W-1:0], c: m[W], z: m[W-1:0] == '0});
         end
      end
   end

   task automatic rand_op();
      case ($urandom_range(0, 3))
         0: in_amt = $urandom_range(0, W + 2);
         1: in_amt = $urandom;
         2: in_amt = W - $urandom_range(0, 1);
         default: in_amt = $urandom_range(0, W - 1);
      endcase
      in_data = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      in_op = 3'($urandom_range(0, 7));
   endtask

   // Single op into an empty pipeline: checks latency and literal results, and pins the model
   task automatic run1(input string nm, input logic [W-1:0] d, input logic [31:0] a, input logic [2:0] o,
                       input logic [W-1:0] ed, input logic ec);
      logic [W:0] m;
      int cyc;
      bit got;
      m = model(d, a, o);
      chk({nm, " model data"}, m[W-1:0], ed);
      chk({nm, " model carry"}, m[W], ec);
      in_valid = 1'b1; in_data = d; in_amt = a; in_op = o; out_ready = 1'b1;
      @(negedge clk);
      chk({nm, " in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) begin got = 1'b1; break; end
         @(posedge clk); #1;
         cyc++;
      end
      chk({nm, " latency"}, got ? cyc : -1, S);
      chk({nm, " data"}, out_data, ed);
      chk({nm, " carry"}, out_carry, ec);
      chk({nm, " zero"}, out_zero, ed == '0);
      @(posedge clk); #1;
   endtask

   task automatic drain(input string nm);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk); #1;
      end
      chk({nm, " drain pending"}, exp_q.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      int first, last, nout, acc;
      logic [W-1:0] held;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst out_valid", out_valid, 0);
      chk("rst out_data", out_data, 0);
      chk("rst out_zero", out_zero, 0);
      chk("rst out_carry", out_carry, 0);
      chk("rst in_ready", in_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post-rst in_ready", in_ready, 1);
      chk("post-rst out_valid", out_valid, 0);
      @(posedge clk); #1;

      run1("sra4", 32'h8000_0000, 4, 3'd2, 32'hF800_0000, 1'b0);
      run1("sra40", 32'h8000_0001, 40, 3'd2, 32'hFFFF_FFFF, 1'b1);
      run1("srl40", 32'h8000_0001, 40, 3'd1, 32'h0, 1'b0);
      run1("sll32", 32'h1, 32, 3'd0, 32'h0, 1'b1);
      run1("sll31", 32'h1, 31, 3'd0, 32'h8000_0000, 1'b0);
      run1("srl32", 32'h8000_0000, 32, 3'd1, 32'h0, 1'b1);
      run1("rol33", 32'h8000_0001, 33, 3'd3, 32'h0000_0003, 1'b1);
      run1("ror1", 32'h1, 1, 3'd4, 32'h8000_0000, 1'b1);
      run1("ror0", 32'h1234_5678, 0, 3'd4, 32'h1234_5678, 1'b0);
      run1("ror32", 32'hA5A5_A5A5, 32, 3'd4, 32'hA5A5_A5A5, 1'b0);
      run1("rsvd", 32'h0, 7, 3'd6, 32'h0, 1'b0);
      run1("rsvd2", 32'h0F0F_0001, 9, 3'd5, 32'h0F0F_0001, 1'b0);

      first = -1; last = -1; nout = 0;
      for (int c = 0; c < 8 + S + 3; c++) begin
         in_valid = c < 8;
         rand_op();
         @(negedge clk);
         if (c < 8) chk("stream in_ready", in_ready, 1);
         if (out_valid) begin
            if (first < 0) first = c;
            last = c;
            nout++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("stream results", nout, 8);
      chk("stream contiguous", last - first, 7);
      chk("stream first latency", first, S);

      acc = 0;
      held = '0;
      for (int c = 0; c < 14; c++) begin
         in_valid = c < 12;
         rand_op();
         out_ready = !(c >= 4 && c < 9);
         @(negedge clk);
         if (c >= 4 && c < 9 && in_valid && in_ready) acc++;
         if (c == 4) held = out_data;
         if (c == 8) begin
            chk("bp in_ready low", in_ready, 0);
            chk("bp out_valid", out_valid, 1);
            chk("bp data held", out_data, held);
         end
         @(posedge clk); #1;
      end
      chk("bp stall accepts bounded", acc <= S, 1);
      drain("bp");

      for (int c = 0; c < 2; c++) begin
         in_valid = 1'b1;
         rand_op();
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst out_valid", out_valid, 0);
      chk("midrst out_data", out_data, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst in_ready", in_ready, 1);
      for (int c = 0; c < S + 3; c++) begin
         chk("midrst no stale", out_valid, 0);
         @(posedge clk); #1;
         @(negedge clk);
      end
      @(posedge clk); #1;

      for (int c = 0; c < 3000; c++) begin
         rst = $urandom_range(0, 599) == 0;
         in_valid = $urandom_range(0, 9) < 7;
         out_ready = $urandom_range(0, 9) < 7;
         rand_op();
         @(posedge clk); #1;
      end
      rst = 1'b0;
      @(posedge clk); #1;
      drain("random");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
